// File: rtl/chan_rr_sampler_pkg.sv
// rtl/chan_rr_sampler_pkg.sv - shared constants and state encoding for the round-robin sampler
package chan_rr_sampler_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return {{(NCH-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter, search starts at ptr and wraps upward
module rr_arbiter_4
  import chan_rr_sampler_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit to ptr is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/chan_rr_sampler.sv
// rtl/chan_rr_sampler.sv - steers the shared channel mux, captures its word and hands it downstream
module chan_rr_sampler
  import chan_rr_sampler_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  output logic [SEL_W-1:0]   sel,
  input  logic [WIDTH-1:0]   mux_data,
  output logic [NCH-1:0]     gnt,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_cnt
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   winner;
  logic               any_req;

  rr_arbiter_4 u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // sel was registered last cycle, so mux_data has settled for this channel.
        data_d  = mux_data;
        ch_d    = sel_q;
        valid_d = 1'b1;
        gnt_d   = sel_onehot(sel_q);
        ptr_d   = sel_q + SEL_W'(1);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign out_data   = data_q;
  assign out_ch     = ch_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_chan_rr_sampler.sv
// tb/tb_chan_rr_sampler.sv - randomized bench for chan_rr_sampler against a transaction-level model
module tb_chan_rr_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        out_ready;
  logic [9:0]  mux_tab [4];

  logic [1:0]  sel, sel2;
  logic [9:0]  mux_data, mux_data2;
  logic [3:0]  gnt, gnt2;
  logic [9:0]  out_data, out_data2;
  logic [1:0]  out_ch, out_ch2;
  logic        out_valid, out_valid2;
  logic        busy, busy2;
  logic [15:0] sample_cnt;
  logic [3:0]  sample_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int last_valid_cyc = -1;

  assign mux_data  = mux_tab[sel];
  assign mux_data2 = mux_tab[sel2];

  chan_rr_sampler #(.WIDTH(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .sel(sel), .mux_data(mux_data), .gnt(gnt),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sample_cnt(sample_cnt)
  );

  // Narrow counter copy so wrap-around is reachable in a short run.
  chan_rr_sampler #(.WIDTH(10), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .req(req), .sel(sel2), .mux_data(mux_data2), .gnt(gnt2),
    .out_data(out_data2), .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready),
    .busy(busy2), .sample_cnt(sample_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_mux;
    for (int i = 0; i < 4; i++) mux_tab[i] = 10'($urandom);
  endtask

  // One full request -> capture -> handshake, with optional backpressure and request drop.
  task automatic do_sample(input logic [3:0] r, input int stall, input bit drop);
    int         exp_ch;
    logic [9:0] exp_data;
    exp_ch = pick(r, m_ptr);
    scramble_mux();
    exp_data  = mux_tab[exp_ch];
    req       = r;
    out_ready = (stall == 0);
    step();
    check("sel_after_arb", sel, exp_ch);
    check("busy_after_arb", busy, 1);
    check("valid_before_cap", out_valid, 0);
    req = drop ? 4'b0000 : 4'($urandom);
    step();
    check("valid_after_cap", out_valid, 1);
    check("out_data", out_data, exp_data);
    check("out_ch", out_ch, exp_ch);
    check("gnt", gnt, 32'(1) << exp_ch);
    check("dut_w_out_ch", out_ch2, exp_ch);
    if (last_valid_cyc >= 0 && stall == 0 && last_valid_cyc + 3 == cyc) checks++;
    last_valid_cyc = cyc;
    m_ptr = (exp_ch + 1) % 4;
    for (int i = 0; i < stall; i++) begin
      scramble_mux();
      req = 4'($urandom);
      step();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_ch", out_ch, exp_ch);
      check("hold_sel", sel, exp_ch);
      check("hold_gnt", gnt, 0);
    end
    out_ready = 1'b1;
    step();
    m_cnt++;
    check("valid_after_hs", out_valid, 0);
    check("busy_after_hs", busy, 0);
    check("sample_cnt", sample_cnt, m_cnt % 65536);
    check("sample_cnt_w", sample_cnt2, m_cnt % 16);
    req = 4'b0000;
  endtask

  initial begin
    int prev_cyc;
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) mux_tab[i] = 10'(i);
    step();
    check("rst_valid", out_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_gnt", gnt, 0);
    check("rst_cnt", sample_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", out_valid, 0);
      check("idle_sel", sel, 0);
      check("idle_busy", busy, 0);
      check("idle_cnt", sample_cnt, 0);
    end

    // Directed single request on channel 2 with a known mux word.
    req = 4'b0100;
    out_ready = 1'b1;
    mux_tab[2] = 10'h2A5;
    step();
    check("dir_sel", sel, 2);
    step();
    check("dir_data", out_data, 10'h2A5);
    check("dir_ch", out_ch, 2);
    check("dir_gnt", gnt, 4'b0100);
    req = 4'b0000;
    step();
    check("dir_cnt", sample_cnt, 1);
    m_cnt = 1;
    m_ptr = 3;

    // Re-align so the all-high sweep starts at channel 0.
    do_sample(4'b1000, 0, 1'b0);
    last_valid_cyc = -1;
    prev_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      do_sample(4'b1111, 0, 1'b0);
      check("rr_seq", out_ch, i % 4);
      if (prev_cyc >= 0) check("rr_spacing", last_valid_cyc - prev_cyc, 3);
      prev_cyc = last_valid_cyc;
    end

    do_sample(4'b0011, 5, 1'b0);
    do_sample(4'b0010, 0, 1'b1);
    check("drop_ptr_model", m_ptr, 2);
    do_sample(4'b1111, 0, 1'b0);
    check("after_drop_ch", out_ch, 2);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      do_sample(r, $urandom_range(0, 3), 1'($urandom));
    end

    // Async reset while a sample is held.
    req = 4'b0110;
    out_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_gnt", gnt, 0);
    check("async_sel", sel, 0);
    check("async_busy", busy, 0);
    check("async_cnt", sample_cnt, 0);
    #1 rst = 1'b0;
    req = 4'b0000;
    m_ptr = 0;
    m_cnt = 0;
    step();
    do_sample(4'b1111, 0, 1'b0);
    check("post_rst_ch", out_ch, 0);

    // Narrow counter wraps after 16 handshakes.
    for (int i = 0; i < 16; i++) do_sample(4'($urandom_range(1, 15)), 0, 1'b0);
    check("wrap_cnt_w", sample_cnt2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
